fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the instruction decoder/controller and supplies its 32-bit instruction word.
- Maintains the PC and issues in-order requests to instruction memory, which may respond with variable latency.
- Buffers returned words in a small queue and presents them with a valid/ready handshake.
- Accepts branch redirects from the execute stage; on a redirect it flushes the queue and discards responses still in flight.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory byte address
- DEPTH, 2, instruction queue entries; also the maximum outstanding requests plus queued words
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- BUBBLE_INSTR, 32'hE1A0_0000, word driven on IR_out whenever IR_valid=0 (MOV r0,r0)

Ports:
- CLOCK_50  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous reset, active-low
- imem_req  out  1  request valid toward instruction memory
- imem_addr  out  ADDR_W  word-aligned fetch address; bits [1:0] always 00
- imem_ack  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response word valid; responses return in request order
- imem_rdata  in  32  response word
- IR_out  out  32  instruction to controller
- IR_valid  out  1  IR_out holds a real instruction
- IR_ready  in  1  controller consumes IR_out this cycle
- PC_out  out  ADDR_W  address of IR_out + 8 (ARM-visible PC); 0 when IR_valid=0
- redirect  in  1  branch taken; one-cycle pulse
- redirect_addr  in  ADDR_W  branch target; bits [1:0] are ignored and forced to 00

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - fetch_pc=RESET_VECTOR; queue empty; inflight=0; discard=0; state=BOOT.
  - imem_req=0, imem_addr=RESET_VECTOR, IR_valid=0, IR_out=BUBBLE_INSTR, PC_out=0.
- Reset asserted mid-operation drops everything immediately. Responses arriving after reset release are not discarded: the memory is required to be reset by the same RESET_N.
- FSM states:
  - BOOT: one cycle, no requests; then RUN.
  - RUN: normal operation.
  - DRAIN: discard>0. Issue is still allowed. Return to RUN when discard reaches 0.
- Issue rule: imem_req=1 iff state!=BOOT and (inflight + count) < DEPTH. imem_addr=fetch_pc.
- Request accept: on imem_req & imem_ack, fetch_pc += 4, wrapping modulo 2^ADDR_W, and inflight increments.
- Response handling: on imem_rvalid, inflight decrements.
  - If discard>0: the word is dropped and discard decrements.
  - Otherwise: push {word, addr} into the queue. Credit accounting guarantees the queue is never full at this point; an overflow is a checked assertion.
- Output path:
  - IR_valid = queue non-empty; IR_out = head word, else BUBBLE_INSTR.
  - Pop on IR_valid & IR_ready.
  - Latency: a word returned at edge N is visible on IR_out after that edge (no extra register).
- Push and pop in the same cycle are both honoured.
- Redirect (sampled at the clock edge):
  - Queue cleared.
  - fetch_pc = {redirect_addr[ADDR_W-1:2], 2'b00}.
  - discard = inflight after this cycle's accept/response updates, i.e. every request issued before the redirect is dropped.
  - state = DRAIN if discard>0, else RUN.
- Simultaneous events with redirect:
  - redirect & IR_ready: the pop is irrelevant; the queue is cleared.
  - redirect & imem_ack: the request at the old PC counts as in-flight and is discarded.
  - redirect & imem_rvalid: that word is dropped without consuming discard.
  - Redirect during DRAIN: discard is recomputed as above.
- IR_ready while IR_valid=0 is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef instr_t (logic [31:0])
  - constant NOP_INSTR = 32'hE1A0_0000
  - constant RESET_VECTOR
  - enum fetch_state_t {BOOT, RUN, DRAIN}
- One sub-module: fetch_queue, a parameterised DEPTH-entry FIFO of {instr_t, addr}.
  - Ports: push, pop, flush, count, head.
  - Asynchronous active-low reset.
- The FSM, credit counters and PC logic stay in fetch_unit.

Test Plan:
- Reset release, imem_ack=1, 1-cycle response, IR_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; IR_out streams with PC_out 8,12,16; first request after the BOOT cycle.
- IR_ready=0 for 10 cycles with immediate memory -> exactly 2 requests issued, imem_req then stays 0; IR_out holds the word at 0x0; on IR_ready=1 a new request issues the next cycle.
- Memory latency 3 cycles, redirect to 0x103 while 2 requests are in flight -> both responses dropped, next imem_addr=0x100, first IR_out has PC_out=0x108.
- Redirect in the same cycle as imem_rvalid and imem_ack -> the returned word is not queued, the accepted old-PC request is discarded later, no stale word ever appears with IR_valid=1.
- fetch_pc=32'hFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
- RESET_N dropped mid-stream with 2 in flight -> IR_valid=0 and IR_out=0xE1A0_0000 the same cycle; after release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
package cpu_pkg;

  typedef logic [31:0] instr_t;

  localparam instr_t      NOP_INSTR    = 32'hE1A0_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {instruction, address} pairs.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned CntW   = $clog2(DEPTH + 1),
  localparam int unsigned EntryW = $bits(instr_t) + ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush,
  input  logic              push,
  input  logic [EntryW-1:0] push_data,
  input  logic              pop,
  output logic [CntW-1:0]   count,
  output logic [EntryW-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    // A push into a full queue without a pop is dropped and flagged below.
    do_push  = push && !flush && ((count_q != CntW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && !flush && !(pop && (count_q != '0)) && (count_q == CntW'(DEPTH))))
    else $error("fetch_queue overflow");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// response queueing and branch redirect with in-flight response discard.
module fetch_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DEPTH        = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(cpu_pkg::RESET_VECTOR),
  parameter logic [31:0]       BUBBLE_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       IR_out,
  output logic              IR_valid,
  input  logic              IR_ready,
  output logic [ADDR_W-1:0] PC_out,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);
  import cpu_pkg::*;

  localparam int unsigned       CntW     = $clog2(DEPTH + 1);
  localparam int unsigned       EntryW   = $bits(instr_t) + ADDR_W;
  localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ResetPc  = RESET_VECTOR & WordMask;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [CntW-1:0]   discard_q, discard_d;

  logic [CntW-1:0]   q_count;
  logic [EntryW-1:0] q_head;
  logic [EntryW-1:0] q_wdata;
  logic              q_push, q_pop;
  logic              accept;
  logic [CntW:0]     credits_used;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] head_pc;
  instr_t            head_instr;

  // Issue is limited so every outstanding response is guaranteed a queue slot.
  always_comb begin
    credits_used = {1'b0, inflight_q} + {1'b0, q_count};
    imem_req     = (state_q != BOOT) && (credits_used < (CntW + 1)'(DEPTH));
    imem_addr    = fetch_pc_q;
  end

  always_comb begin
    target_pc  = redirect_addr & WordMask;
    accept     = imem_req && imem_ack;
    inflight_d = inflight_q + CntW'(accept) - CntW'(imem_rvalid);
    q_push     = imem_rvalid && (discard_q == '0) && !redirect;
    q_pop      = IR_valid && IR_ready && !redirect;
    q_wdata    = {imem_rdata, rsp_pc_q};

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    // rsp_pc tracks the address of the next response that will be kept.
    if (q_push) rsp_pc_d = rsp_pc_q + ADDR_W'(4);
    if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (redirect) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      discard_d  = inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:       state_d = RUN;
      RUN, DRAIN: state_d = (discard_d != '0) ? DRAIN : RUN;
      default:    state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= BOOT;
      fetch_pc_q <= ResetPc;
      rsp_pc_q   <= ResetPc;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_queue (
    .clk_i    (CLOCK_50),
    .rst_ni   (RESET_N),
    .flush    (redirect),
    .push     (q_push),
    .push_data(q_wdata),
    .pop      (q_pop),
    .count    (q_count),
    .head     (q_head)
  );

  always_comb begin
    head_instr = q_head[EntryW-1 -: $bits(instr_t)];
    head_pc    = q_head[ADDR_W-1:0];
    IR_valid   = (q_count != '0);
    IR_out     = IR_valid ? head_instr : BUBBLE_INSTR;
    // ARM-visible PC runs two instructions ahead of the executing one.
    PC_out     = IR_valid ? head_pc + ADDR_W'(8) : '0;
  end

  rsp_without_req_a: assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
      imem_rvalid |-> (inflight_q != '0))
    else $error("fetch_unit: response with nothing in flight");

  discard_bound_a: assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
      discard_q <= inflight_q)
    else $error("fetch_unit: discard exceeds in-flight count");

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against an epoch-tagged memory/queue model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IR_out;
  logic        IR_valid;
  logic        IR_ready;
  logic [31:0] PC_out;
  logic        redirect;
  logic [31:0] redirect_addr;

  always #5 CLOCK_50 = ~CLOCK_50;

  fetch_unit #(
    .ADDR_W      (32),
    .DEPTH       (DEPTH),
    .RESET_VECTOR(32'h0000_0000),
    .BUBBLE_INSTR(32'hE1A0_0000)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .IR_out       (IR_out),
    .IR_valid     (IR_valid),
    .IR_ready     (IR_ready),
    .PC_out       (PC_out),
    .redirect     (redirect),
    .redirect_addr(redirect_addr)
  );

  // Each memory request remembers which redirect epoch issued it.
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] con_log[$];
  logic [31:0] m_pc;
  int unsigned m_epoch;
  int unsigned cyc;
  bit          m_boot;
  int unsigned checks;
  int unsigned errors;

  int unsigned lat_min, lat_max, p_ack, p_rv, p_ready, p_redir;
  bit          force_redir;
  logic [31:0] force_addr;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
    return t;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD1;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int unsigned lmin, input int unsigned lmax, input int unsigned pa,
                       input int unsigned pv, input int unsigned pr, input int unsigned pd);
    lat_min = lmin; lat_max = lmax; p_ack = pa; p_rv = pv; p_ready = pr; p_redir = pd;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model.
  task automatic cycle();
    logic        req_e, a, rv, rdy, rd;
    logic [31:0] ra, tmp;
    mreq_t       r;
    req_e = !m_boot && ((mem_q.size() + mq.size()) < DEPTH);
    chk1("imem_req", imem_req, req_e);
    chk32("imem_addr", imem_addr, m_pc);
    chk1("IR_valid", IR_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk32("IR_out", IR_out, word_of(mq[0]));
      chk32("PC_out", PC_out, mq[0] + 32'd8);
    end else begin
      chk32("IR_out bubble", IR_out, 32'hE1A0_0000);
      chk32("PC_out idle", PC_out, 32'd0);
    end

    a   = ($urandom % 100) < p_ack;
    rv  = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && (($urandom % 100) < p_rv);
    rdy = ($urandom % 100) < p_ready;
    rd  = force_redir || (($urandom % 1000) < p_redir);
    ra  = force_redir ? force_addr : rand_target();
    imem_ack      = a;
    imem_rvalid   = rv;
    imem_rdata    = rv ? word_of(mem_q[0].addr) : $urandom;
    IR_ready      = rdy;
    redirect      = rd;
    redirect_addr = ra;

    if ((mq.size() != 0) && rdy && !rd) begin
      con_log.push_back(mq[0] + 32'd8);
      tmp = mq.pop_front();
    end
    if (rv) begin
      r = mem_q.pop_front();
      if ((r.epoch == m_epoch) && !rd) mq.push_back(r.addr);
    end
    if (req_e && a) begin
      acc_log.push_back(m_pc);
      mem_q.push_back('{m_pc, m_epoch, cyc + $urandom_range(lat_min, lat_max)});
      m_pc = m_pc + 32'd4;
    end
    if (rd) begin
      m_epoch++;
      mq.delete();
      m_pc = ra & ~32'h3;
    end
    m_boot = 1'b0;
    cyc++;
    @(negedge CLOCK_50);
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    RESET_N       = 1'b0;
    imem_ack      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    IR_ready      = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    #1;
    chk1("reset IR_valid", IR_valid, 1'b0);
    chk32("reset IR_out", IR_out, 32'hE1A0_0000);
    chk32("reset PC_out", PC_out, 32'h0);
    chk1("reset imem_req", imem_req, 1'b0);
    chk32("reset imem_addr", imem_addr, 32'h0);
    mem_q.delete();
    mq.delete();
    acc_log.delete();
    con_log.delete();
    m_pc   = 32'h0;
    m_boot = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  task automatic redirect_now(input logic [31:0] addr);
    force_redir = 1'b1;
    force_addr  = addr;
    cycle();
    force_redir = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; m_epoch = 0; force_redir = 1'b0; force_addr = '0;
    RESET_N = 1'b1; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    IR_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    @(negedge CLOCK_50);

    // Streaming with a one-cycle memory and an always-ready consumer.
    knobs(1, 1, 100, 100, 100, 0);
    do_reset();
    chk1("boot req", imem_req, 1'b0);
    cycle();
    chk32("boot cycle issues nothing", 32'(acc_log.size()), 32'd0);
    cycle();
    chk32("first issue after boot", 32'(acc_log.size()), 32'd1);
    repeat (10) cycle();
    chk32("stream addr0", at(acc_log, 0), 32'h0);
    chk32("stream addr1", at(acc_log, 1), 32'h4);
    chk32("stream addr2", at(acc_log, 2), 32'h8);
    chk32("stream pc0", at(con_log, 0), 32'd8);
    chk32("stream pc1", at(con_log, 1), 32'd12);
    chk32("stream pc2", at(con_log, 2), 32'd16);

    // Consumer stalled: credits cap issue at two requests.
    knobs(1, 1, 100, 100, 0, 0);
    do_reset();
    repeat (10) cycle();
    chk32("stall issued", 32'(acc_log.size()), 32'd2);
    chk1("stall req idle", imem_req, 1'b0);
    chk32("stall IR_out", IR_out, 32'hC3A5_5A3C);
    chk32("stall PC_out", PC_out, 32'h8);
    p_ready = 100;
    cycle();
    p_ready = 0;
    cycle();
    chk32("stall reissue", 32'(acc_log.size()), 32'd3);
    chk32("stall reissue addr", at(acc_log, 2), 32'h8);

    // Redirect with two requests in flight on a 3-cycle memory.
    knobs(3, 3, 100, 100, 100, 0);
    do_reset();
    repeat (3) cycle();
    redirect_now(32'h0000_0103);
    repeat (12) cycle();
    chk32("drain first new addr", at(acc_log, 2), 32'h100);
    chk32("drain first pc", at(con_log, 0), 32'h108);

    // Redirect coinciding with a response and an accept.
    knobs(1, 1, 100, 100, 100, 0);
    do_reset();
    repeat (2) cycle();
    redirect_now(32'h0000_0200);
    repeat (10) cycle();
    chk32("collide old accept", at(acc_log, 1), 32'h4);
    chk32("collide new addr", at(acc_log, 2), 32'h200);
    chk32("collide first pc", at(con_log, 0), 32'h208);

    // PC wrap at the top of the address space.
    do_reset();
    redirect_now(32'hFFFF_FFFE);
    repeat (10) cycle();
    chk32("wrap addr0", at(acc_log, 0), 32'hFFFF_FFFC);
    chk32("wrap addr1", at(acc_log, 1), 32'h0);
    chk32("wrap pc0", at(con_log, 0), 32'h4);
    chk32("wrap pc1", at(con_log, 1), 32'h8);

    // Reset mid-stream with two requests outstanding.
    knobs(3, 3, 100, 100, 100, 0);
    do_reset();
    repeat (3) cycle();
    do_reset();
    repeat (8) cycle();
    chk32("restart addr", at(acc_log, 0), 32'h0);
    chk32("restart pc", at(con_log, 0), 32'h8);

    // Randomised traffic with redirects and occasional resets.
    for (int k = 0; k < 6; k++) begin
      knobs(1, 1 + (k % 4), 50 + 10 * (k % 5), 60 + 8 * (k % 5), 30 + 15 * (k % 4),
            20 + 15 * k);
      do_reset();
      for (int n = 0; n < 2000; n++) begin
        cycle();
        if (($urandom % 700) == 0) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
